// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, signed or unsigned
// operands, 2*WIDTH product returned as hi/lo words with a start/busy/done handshake.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;

    logic               w_lastIter;
    logic [WIDTH-1:0]   w_aMag;
    logic [WIDTH-1:0]   w_bMag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_result;

    // The magnitude of the most negative operand is 2^(WIDTH-1), which still fits unsigned.
    assign w_aMag     = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign w_bMag     = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_result   = r_neg ? -r_acc : r_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (w_lastIter) w_nextState = FIX;
            FIX:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The sum's carry bit becomes the new accumulator MSB as the whole accumulator shifts right.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= w_aMag;
                        r_mplier <= w_bMag;
                        r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    {r_hi, r_lo} <= w_result;
                    r_done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign lo   = r_lo;
    assign hi   = r_hi;
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised multi-cycle shift-add multiplier for the KGP-RISC ALU path.
- Supports signed and unsigned operands, selected per operation.
- Produces a 2*WIDTH product as separate hi and lo words.
- Replaces the flat combinational partial-product array with a one-bit-per-cycle datapath and a start/busy/done handshake, so the core can stall on multiply.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits; legal values are 4 or more.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request a multiply; accepted only when busy=0.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched on accept.
- a  input  WIDTH  multiplicand; latched on accept.
- b  input  WIDTH  multiplier; latched on accept.
- busy  output  1  operation in progress; start ignored while high.
- done  output  1  single-cycle pulse; hi/lo valid from this cycle.
- lo  output  WIDTH  product bits [WIDTH-1:0].
- hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, lo=0, hi=0, counter=0, internal accumulator=0.
  - Reset overrides start at the same edge.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge k: latch |a|, |b| (magnitudes if signed_mode=1, raw values otherwise).
  - Latch the result sign = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear the accumulator, set counter=0, go to RUN, busy=1 after edge k.
- RUN: each edge adds the multiplicand to the upper accumulator half if the current LSB of the multiplier is set, then shifts right one bit (carry preserved into the top bit) and increments counter.
  - After WIDTH iterations (edge k+WIDTH), go to FIX.
- FIX, at edge k+WIDTH+1:
  - Write {hi,lo} = the two's-complement negation of the accumulator if the sign is set, else the accumulator.
  - done=1, busy=0, go to IDLE.
- Fixed latency: done is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+1 edges after the accepting edge.
- done is high for exactly one cycle. hi/lo hold their value until the next FIX write or reset.
- A start in the cycle where done=1 is accepted (back-to-back issue). hi/lo keep the old result until the new FIX.
- start while busy=1: ignored, with no effect on the in-flight operation or on the latched inputs.
- a, b and signed_mode may change freely after the accepting edge.
- Arithmetic:
  - Magnitude of the most negative value (-2^(WIDTH-1)) is 2^(WIDTH-1) and fits in WIDTH unsigned bits.
  - No overflow is possible. Max unsigned product is (2^WIDTH-1)^2; max signed product is 2^(2*WIDTH-2).
  - Zero operands with the sign set yield zero (negation of 0 = 0).
  - The internal add is WIDTH+1 bits wide to keep the carry.

Test Plan:
- WIDTH=32, unsigned, a=7, b=6 -> done exactly 33 edges after accept; hi=0x00000000, lo=0x0000002A; busy high for 33 cycles.
- WIDTH=32, unsigned, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands signed (-1*-1) -> hi=0x00000000, lo=0x00000001.
- WIDTH=32, signed, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - Then a=b=0x80000000 signed -> hi=0x40000000, lo=0x00000000.
  - a=0, b=0x80000000 signed -> hi=lo=0.
- Handshake, WIDTH=32:
  - Operation 2*3 started; at cycle 10 drive start with a=9, b=9 -> ignored; result 6.
  - Start 4*4 in the done cycle -> accepted; second done 33 edges later with lo=0x10; hi/lo read 6 in between.
- Reset mid-operation, WIDTH=32: start 5*5, assert rst_n=0 at edge 15 -> busy=0, done never pulses, hi=lo=0. After release, 5*5 -> lo=25.
- WIDTH=8 instance, signed: a=0x80 (-128), b=0x7F (127) -> {hi,lo}=0xC080 (-16256), done 9 edges after accept. Random compare against a reference model over 1000 mixed-mode vectors.
